// File: rtl/lsu_dtcm_arb.sv
// lsu_dtcm_arb: shares the single DTCM port between the AGU command channel
// and an external slave-access requester. Issued accesses are tracked in a
// 2-entry in-order FIFO so that each DTCM response returns to its issuer.
// Build option: define LSU_ARB_RR_EN for round-robin arbitration; default is
// fixed priority with AGU first.
module lsu_dtcm_arb #(
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int ITAG_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              agu_cmd_valid,
  output logic              agu_cmd_ready,
  input  logic [AW-1:0]     agu_cmd_addr,
  input  logic              agu_cmd_read,
  input  logic [DW-1:0]     agu_cmd_wdata,
  input  logic [DW/8-1:0]   agu_cmd_wmask,
  input  logic [ITAG_W-1:0] agu_cmd_itag,
  output logic              agu_rsp_valid,
  input  logic              agu_rsp_ready,
  output logic [DW-1:0]     agu_rsp_rdata,
  output logic [ITAG_W-1:0] agu_rsp_itag,
  input  logic              ext_cmd_valid,
  output logic              ext_cmd_ready,
  input  logic [AW-1:0]     ext_cmd_addr,
  input  logic              ext_cmd_read,
  input  logic [DW-1:0]     ext_cmd_wdata,
  input  logic [DW/8-1:0]   ext_cmd_wmask,
  output logic              ext_rsp_valid,
  input  logic              ext_rsp_ready,
  output logic [DW-1:0]     ext_rsp_rdata,
  output logic              dtcm_cmd_valid,
  input  logic              dtcm_cmd_ready,
  output logic [AW-1:0]     dtcm_cmd_addr,
  output logic              dtcm_cmd_read,
  output logic [DW-1:0]     dtcm_cmd_wdata,
  output logic [DW/8-1:0]   dtcm_cmd_wmask,
  input  logic              dtcm_rsp_valid,
  output logic              dtcm_rsp_ready,
  input  logic [DW-1:0]     dtcm_rsp_rdata
);

  typedef enum logic {SRC_AGU = 1'b0, SRC_EXT = 1'b1} src_e;

  src_e              fifo_src  [2];
  logic [ITAG_W-1:0] fifo_itag [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              lock_vld;
  src_e              lock_src;
  src_e              last_src;

  logic              can_issue;
  src_e              sel;
  logic              sel_valid;
  logic              push;
  logic              pop;
  logic              rsp_owned;
  src_e              head_src;

  // Pick the source that owns the DTCM command channel this cycle.
  // A lock is only ever set while a slot is free, and no push happens while
  // locked, so can_issue stays true for the whole locked window.
  always_comb begin
    can_issue = (count != 2'd2);
    if (lock_vld) begin
      sel = lock_src;
    end else if (agu_cmd_valid && ext_cmd_valid) begin
`ifdef LSU_ARB_RR_EN
      sel = (last_src == SRC_AGU) ? SRC_EXT : SRC_AGU;
`else
      sel = SRC_AGU;
`endif
    end else if (agu_cmd_valid) begin
      sel = SRC_AGU;
    end else if (ext_cmd_valid) begin
      sel = SRC_EXT;
    end else begin
      // Idle: park the payload mux on the last granted source.
      sel = last_src;
    end
    sel_valid = (sel == SRC_AGU) ? agu_cmd_valid : ext_cmd_valid;
  end

  // Drive the DTCM command channel from the selected source.
  always_comb begin
    dtcm_cmd_valid = can_issue & sel_valid;
    if (sel == SRC_AGU) begin
      dtcm_cmd_addr  = agu_cmd_addr;
      dtcm_cmd_read  = agu_cmd_read;
      dtcm_cmd_wdata = agu_cmd_wdata;
      dtcm_cmd_wmask = agu_cmd_wmask;
    end else begin
      dtcm_cmd_addr  = ext_cmd_addr;
      dtcm_cmd_read  = ext_cmd_read;
      dtcm_cmd_wdata = ext_cmd_wdata;
      dtcm_cmd_wmask = ext_cmd_wmask;
    end
    agu_cmd_ready = dtcm_cmd_ready & dtcm_cmd_valid & (sel == SRC_AGU);
    ext_cmd_ready = dtcm_cmd_ready & dtcm_cmd_valid & (sel == SRC_EXT);
    push          = dtcm_cmd_valid & dtcm_cmd_ready;
  end

  // Steer the DTCM response to the owner recorded at the FIFO head.
  always_comb begin
    rsp_owned      = (count != 2'd0);
    head_src       = fifo_src[rd_ptr];
    agu_rsp_valid  = dtcm_rsp_valid & rsp_owned & (head_src == SRC_AGU);
    ext_rsp_valid  = dtcm_rsp_valid & rsp_owned & (head_src == SRC_EXT);
    agu_rsp_itag   = fifo_itag[rd_ptr];
    agu_rsp_rdata  = dtcm_rsp_rdata;
    ext_rsp_rdata  = dtcm_rsp_rdata;
    dtcm_rsp_ready = rsp_owned &
                     ((head_src == SRC_AGU) ? agu_rsp_ready : ext_rsp_ready);
    pop            = dtcm_rsp_valid & dtcm_rsp_ready;
  end

  // Tracking FIFO payload; storage needs no reset because count gates it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_src[wr_ptr]  <= sel;
      fifo_itag[wr_ptr] <= (sel == SRC_AGU) ? agu_cmd_itag : '0;
    end
  end

  // FIFO pointers/count, grant lock and last-granted source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      lock_vld <= 1'b0;
      lock_src <= SRC_AGU;
      last_src <= SRC_EXT;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push) begin
        lock_vld <= 1'b0;
        last_src <= sel;
      end else if (dtcm_cmd_valid) begin
        lock_vld <= 1'b1;
        lock_src <= sel;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dtcm_arb.sv
// Randomized self-checking bench for lsu_dtcm_arb against a queue-based
// reference model of the arbitration, lock and in-order response routing.
module tb_lsu_dtcm_arb;
  localparam int AW = 16, DW = 32, ITAG_W = 2, MW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic agu_cmd_valid, agu_cmd_ready, agu_cmd_read;
  logic [AW-1:0] agu_cmd_addr;
  logic [DW-1:0] agu_cmd_wdata;
  logic [MW-1:0] agu_cmd_wmask;
  logic [ITAG_W-1:0] agu_cmd_itag;
  logic agu_rsp_valid, agu_rsp_ready;
  logic [DW-1:0] agu_rsp_rdata;
  logic [ITAG_W-1:0] agu_rsp_itag;
  logic ext_cmd_valid, ext_cmd_ready, ext_cmd_read;
  logic [AW-1:0] ext_cmd_addr;
  logic [DW-1:0] ext_cmd_wdata;
  logic [MW-1:0] ext_cmd_wmask;
  logic ext_rsp_valid, ext_rsp_ready;
  logic [DW-1:0] ext_rsp_rdata;
  logic dtcm_cmd_valid, dtcm_cmd_ready, dtcm_cmd_read;
  logic [AW-1:0] dtcm_cmd_addr;
  logic [DW-1:0] dtcm_cmd_wdata;
  logic [MW-1:0] dtcm_cmd_wmask;
  logic dtcm_rsp_valid, dtcm_rsp_ready;
  logic [DW-1:0] dtcm_rsp_rdata;

  always #5 clk = ~clk;

  lsu_dtcm_arb #(.AW(AW), .DW(DW), .ITAG_W(ITAG_W)) dut (
    .clk(clk), .rst(rst),
    .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready),
    .agu_cmd_addr(agu_cmd_addr), .agu_cmd_read(agu_cmd_read),
    .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_wmask(agu_cmd_wmask),
    .agu_cmd_itag(agu_cmd_itag),
    .agu_rsp_valid(agu_rsp_valid), .agu_rsp_ready(agu_rsp_ready),
    .agu_rsp_rdata(agu_rsp_rdata), .agu_rsp_itag(agu_rsp_itag),
    .ext_cmd_valid(ext_cmd_valid), .ext_cmd_ready(ext_cmd_ready),
    .ext_cmd_addr(ext_cmd_addr), .ext_cmd_read(ext_cmd_read),
    .ext_cmd_wdata(ext_cmd_wdata), .ext_cmd_wmask(ext_cmd_wmask),
    .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready),
    .ext_rsp_rdata(ext_rsp_rdata),
    .dtcm_cmd_valid(dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready),
    .dtcm_cmd_addr(dtcm_cmd_addr), .dtcm_cmd_read(dtcm_cmd_read),
    .dtcm_cmd_wdata(dtcm_cmd_wdata), .dtcm_cmd_wmask(dtcm_cmd_wmask),
    .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(dtcm_rsp_ready),
    .dtcm_rsp_rdata(dtcm_rsp_rdata)
  );

  int unsigned n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: outstanding accesses as a queue of {is_ext, itag}.
  typedef struct packed { logic is_ext; logic [ITAG_W-1:0] itag; } ent_t;
  ent_t          outq[$];
  logic [DW-1:0] dtcm_q[$];   // rdata the DTCM will return, in order
  bit            m_lock, m_lock_ext, m_last_ext;
  bit            agu_done, ext_done, rsp_done;
  logic [ITAG_W-1:0] itag_ctr;
  int            p_agu, p_ext, p_crdy, p_rv, p_arr, p_err;

  function automatic bit chance(input int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic set_knobs(input int a, input int e, input int c, input int v, input int ar, input int er);
    p_agu = a; p_ext = e; p_crdy = c; p_rv = v; p_arr = ar; p_err = er;
  endtask

  task automatic model_reset();
    outq.delete();
    m_lock = 0; m_lock_ext = 0; m_last_ext = 1;
    agu_done = 0; ext_done = 0; rsp_done = 0;
  endtask

  task automatic run_cycle();
    bit can, sx, sv, e_cv, has, e_rr, push, pop;
    @(negedge clk);
    if (agu_done) agu_cmd_valid = 0;
    if (ext_done) ext_cmd_valid = 0;
    if (rsp_done) dtcm_rsp_valid = 0;
    agu_done = 0; ext_done = 0; rsp_done = 0;
    if (!agu_cmd_valid && chance(p_agu)) begin
      agu_cmd_valid = 1; agu_cmd_addr = AW'($urandom); agu_cmd_read = 1'($urandom);
      agu_cmd_wdata = $urandom; agu_cmd_wmask = MW'($urandom);
      agu_cmd_itag = itag_ctr; itag_ctr = itag_ctr + 1'b1;
    end
    if (!ext_cmd_valid && chance(p_ext)) begin
      ext_cmd_valid = 1; ext_cmd_addr = AW'($urandom); ext_cmd_read = 1'($urandom);
      ext_cmd_wdata = $urandom; ext_cmd_wmask = MW'($urandom);
    end
    dtcm_cmd_ready = chance(p_crdy);
    if (!dtcm_rsp_valid && dtcm_q.size() > 0 && chance(p_rv)) begin
      dtcm_rsp_valid = 1; dtcm_rsp_rdata = dtcm_q[0];
    end
    agu_rsp_ready = chance(p_arr);
    ext_rsp_ready = chance(p_err);
    #1;
    can = outq.size() < 2;
    if (m_lock) sx = m_lock_ext;
    else if (agu_cmd_valid && ext_cmd_valid) begin
`ifdef LSU_ARB_RR_EN
      sx = !m_last_ext;
`else
      sx = 0;
`endif
    end else sx = !agu_cmd_valid;
    sv   = sx ? ext_cmd_valid : agu_cmd_valid;
    e_cv = can && sv;
    check("dtcm_cmd_valid", dtcm_cmd_valid, e_cv);
    check("agu_cmd_ready", agu_cmd_ready, e_cv && dtcm_cmd_ready && !sx);
    check("ext_cmd_ready", ext_cmd_ready, e_cv && dtcm_cmd_ready && sx);
    if (e_cv) begin
      check("dtcm_cmd_addr",  dtcm_cmd_addr,  sx ? ext_cmd_addr  : agu_cmd_addr);
      check("dtcm_cmd_read",  dtcm_cmd_read,  sx ? ext_cmd_read  : agu_cmd_read);
      check("dtcm_cmd_wdata", dtcm_cmd_wdata, sx ? ext_cmd_wdata : agu_cmd_wdata);
      check("dtcm_cmd_wmask", dtcm_cmd_wmask, sx ? ext_cmd_wmask : agu_cmd_wmask);
    end
    has  = outq.size() > 0;
    e_rr = has && (outq[0].is_ext ? ext_rsp_ready : agu_rsp_ready);
    check("agu_rsp_valid", agu_rsp_valid, dtcm_rsp_valid && has && !outq[0].is_ext);
    check("ext_rsp_valid", ext_rsp_valid, dtcm_rsp_valid && has && outq[0].is_ext);
    check("dtcm_rsp_ready", dtcm_rsp_ready, e_rr);
    if (dtcm_rsp_valid && has && !outq[0].is_ext) begin
      check("agu_rsp_itag", agu_rsp_itag, outq[0].itag);
      check("agu_rsp_rdata", agu_rsp_rdata, dtcm_q[0]);
    end
    if (dtcm_rsp_valid && has && outq[0].is_ext)
      check("ext_rsp_rdata", ext_rsp_rdata, dtcm_q[0]);
    push = e_cv && dtcm_cmd_ready;
    pop  = dtcm_rsp_valid && e_rr;
    if (pop) begin
      void'(outq.pop_front()); void'(dtcm_q.pop_front()); rsp_done = 1;
    end
    if (push) begin
      outq.push_back('{is_ext: sx, itag: sx ? '0 : agu_cmd_itag});
      dtcm_q.push_back($urandom);
      m_last_ext = sx; m_lock = 0;
      if (sx) ext_done = 1; else agu_done = 1;
    end else if (e_cv) begin
      m_lock = 1; m_lock_ext = sx;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // Reset mid-operation: stray DTCM responses must not reach any requester.
  task automatic mid_reset();
    @(negedge clk);
    rst = 1; agu_cmd_valid = 0; ext_cmd_valid = 0;
    if (!dtcm_rsp_valid && dtcm_q.size() > 0) begin
      dtcm_rsp_valid = 1; dtcm_rsp_rdata = dtcm_q[0];
    end
    model_reset();
    #1;
    check("rst_cmd_valid", dtcm_cmd_valid, 1'b0);
    check("rst_rsp_ready", dtcm_rsp_ready, 1'b0);
    check("rst_agu_rsp", agu_rsp_valid, 1'b0);
    check("rst_ext_rsp", ext_rsp_valid, 1'b0);
    @(negedge clk);
    rst = 0;
    set_knobs(0, 0, 100, 100, 100, 100);
    run(3);
    dtcm_q.delete(); dtcm_rsp_valid = 0;
  endtask

  initial begin
    rst = 1; itag_ctr = '0;
    {agu_cmd_valid, agu_cmd_read, agu_cmd_addr, agu_cmd_wdata, agu_cmd_wmask, agu_cmd_itag} = '0;
    {ext_cmd_valid, ext_cmd_read, ext_cmd_addr, ext_cmd_wdata, ext_cmd_wmask} = '0;
    {dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata, agu_rsp_ready, ext_rsp_ready} = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_cmd_valid", dtcm_cmd_valid, 1'b0);
    check("reset_agu_ready", agu_cmd_ready, 1'b0);
    check("reset_ext_ready", ext_cmd_ready, 1'b0);
    check("reset_agu_rsp", agu_rsp_valid, 1'b0);
    check("reset_ext_rsp", ext_rsp_valid, 1'b0);
    check("reset_rsp_ready", dtcm_rsp_ready, 1'b0);
    rst = 0;

    set_knobs(100, 0, 100, 100, 100, 100);   run(12);  // AGU-only streaming
    set_knobs(100, 100, 100, 100, 100, 100); run(20);  // both always request
    set_knobs(0, 0, 100, 100, 100, 100);     run(4);   // drain
    set_knobs(0, 100, 0, 100, 100, 100);     run(1);   // EXT granted, stalled
    set_knobs(100, 100, 0, 100, 100, 100);   run(3);   // AGU arrives while locked
    set_knobs(100, 100, 100, 100, 100, 100); run(6);
    set_knobs(100, 100, 100, 0, 100, 100);   run(6);   // DTCM withholds: FIFO full
    set_knobs(100, 100, 100, 100, 100, 100); run(6);
    set_knobs(0, 100, 100, 100, 100, 0);     run(6);   // EXT response back-pressure
    set_knobs(0, 0, 100, 100, 100, 100);     run(6);

    for (int blk = 0; blk < 40; blk++) begin
      set_knobs($urandom_range(100), $urandom_range(100), $urandom_range(100),
                $urandom_range(100), $urandom_range(100), $urandom_range(100));
      run(50);
    end

    set_knobs(100, 100, 100, 0, 100, 100);   run(5);   // fill to count=2
    set_knobs(100, 100, 0, 0, 100, 100);     run(2);
    mid_reset();
    set_knobs(100, 100, 30, 0, 100, 100);    run(3);   // likely locked
    mid_reset();
    set_knobs(60, 60, 70, 70, 70, 70);       run(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
